// File: rtl/swipt_bridge_pwm_if.sv
// Runtime configuration port of the SWIPT full-bridge gate driver.
// A word transfers on any edge where cfg_valid and cfg_ready are both high.
interface swipt_bridge_pwm_if #(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned DT_W  = 6
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CNT_W-1:0] cfg_half;
    logic [CNT_W-1:0] cfg_on;
    logic [DT_W-1:0]  cfg_dt;
    logic             cfg_err;

    modport master (
        output cfg_valid, cfg_half, cfg_on, cfg_dt,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_half, cfg_on, cfg_dt,
        output cfg_ready, cfg_err
    );
endinterface

// File: rtl/swipt_bridge_pwm.sv
// Full-bridge gate driver: gate[0] left-high, gate[1] right-high, gate[2] left-low, gate[3] right-low.
// Double-buffered period/on/dead-time config, per-leg dead time, latched fault shutdown.
module swipt_bridge_pwm #(
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned DT_W     = 6,
    parameter int unsigned DEF_HALF = 625,
    parameter int unsigned DEF_ON   = 312,
    parameter int unsigned DEF_DT   = 15
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                en,
    input  logic                fault,
    swipt_bridge_pwm_if.slave   cfg,
    output logic [3:0]          gate,
    output logic                phase,
    output logic                cyc_start,
    output logic                fault_active
);
    typedef enum logic {PH_POS = 1'b0, PH_NEG = 1'b1} phase_e;

    phase_e           ph;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] half_a, on_a, half_s, on_s;
    logic [DT_W-1:0]  dt_a, dt_s;
    logic             pending;
    logic             err_q;
    logic             run, last_cnt, period_end, accept, word_ok;
    logic [3:0]       dmd, partner;
    logic [DT_W-1:0]  dtc [4];

    assign run        = en & ~fault_active;
    assign last_cnt   = (cnt == half_a - CNT_W'(1));
    assign period_end = run & last_cnt & (ph == PH_NEG);
    assign accept     = cfg.cfg_valid & ~pending;
    assign word_ok    = (cfg.cfg_half >= CNT_W'(2)) && (cfg.cfg_on <= cfg.cfg_half);

    assign cfg.cfg_ready = ~pending;
    assign cfg.cfg_err   = err_q;
    assign phase         = (ph == PH_NEG);
    assign cyc_start     = run & (cnt == '0) & (ph == PH_POS);

    // Other switch of the same leg: (0,2) and (1,3).
    assign partner = {gate[1], gate[0], gate[3], gate[2]};

    always_comb begin
        dmd = 4'b1100;
        if (run && (cnt < on_a)) begin
            dmd = (ph == PH_NEG) ? 4'b0110 : 4'b1001;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt <= '0;
            ph  <= PH_POS;
        end else if (!run) begin
            cnt <= '0;
            ph  <= PH_POS;
        end else if (last_cnt) begin
            cnt <= '0;
            ph  <= (ph == PH_POS) ? PH_NEG : PH_POS;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Apply and accept are exclusive: accept needs pending=0, apply needs pending=1.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            half_a  <= CNT_W'(DEF_HALF);
            on_a    <= CNT_W'(DEF_ON);
            dt_a    <= DT_W'(DEF_DT);
            half_s  <= '0;
            on_s    <= '0;
            dt_s    <= '0;
            pending <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            err_q <= accept & ~word_ok;
            if (pending && (period_end || !run)) begin
                half_a  <= half_s;
                on_a    <= on_s;
                dt_a    <= dt_s;
                pending <= 1'b0;
            end else if (accept && word_ok) begin
                half_s  <= cfg.cfg_half;
                on_s    <= cfg.cfg_on;
                dt_s    <= cfg.cfg_dt;
                pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            fault_active <= 1'b0;
        end else if (fault) begin
            fault_active <= 1'b1;
        end else if (!en) begin
            fault_active <= 1'b0;
        end
    end

    // Fault (raw or latched) forces all switches off and restarts every dead-time count.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            gate <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                dtc[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (fault || fault_active || !dmd[i] || partner[i]) begin
                    gate[i] <= 1'b0;
                    dtc[i]  <= '0;
                end else if (dtc[i] == dt_a) begin
                    gate[i] <= 1'b1;
                end else begin
                    dtc[i] <= dtc[i] + DT_W'(1);
                end
            end
        end
    end
endmodule
